// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory/I-O stage.
package slc3_mem_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [WORD_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_INIT,
    S_DRAIN,
    S_RUN
  } mem_state_t;

endpackage

// File: rtl/slc3_mem_subsystem_sync2.sv
// Two-flop synchronizer for asynchronous board inputs, synchronously cleared.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/slc3_mem_subsystem.sv
// Copies the ROM program image into BRAM after reset, then serves core accesses
// with 1-cycle read latency and one memory-mapped I/O word (switches / hex display).
module slc3_mem_subsystem
  import slc3_mem_pkg::*;
#(
  parameter int unsigned       INIT_WORDS = 256,
  parameter logic [WORD_W-1:0] IO_ADDR    = IO_ADDR_DEFAULT,
  parameter int unsigned       BRAM_AW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_mem_ena,
  input  logic                mem_wr_ena,
  output logic [WORD_W-1:0]   mem_rdata,
  input  logic [WORD_W-1:0]   sw_i,
  output logic [WORD_W-1:0]   hex_o,
  output logic                cpu_hold,
  output logic                init_done,
  output logic [BRAM_AW-1:0]  rom_addr,
  input  logic [WORD_W-1:0]   rom_data,
  output logic                bram_en,
  output logic                bram_we,
  output logic [BRAM_AW-1:0]  bram_addr,
  output logic [WORD_W-1:0]   bram_wdata,
  input  logic [WORD_W-1:0]   bram_rdata
);

  localparam logic [15:0] LAST_CNT = 16'(INIT_WORDS - 1);

  mem_state_t         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [BRAM_AW-1:0] cnt_prev_q;
  logic               pend_q;
  logic               cpu_hold_q;
  logic               init_done_q;
  logic               rd_pend_q;
  logic               io_sel_q;
  logic [WORD_W-1:0]  rdata_hold_q;
  logic [WORD_W-1:0]  hex_q;
  logic [WORD_W-1:0]  sw_sync;

  logic is_io;
  logic run;
  logic core_rd;
  logic core_io_wr;

  sync2 #(
    .WIDTH (WORD_W)
  ) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_i),
    .q     (sw_sync)
  );

  assign is_io      = (mem_addr == IO_ADDR);
  assign run        = (state_q == S_RUN);
  assign core_rd    = run && mem_mem_ena && !mem_wr_ena;
  assign core_io_wr = run && mem_mem_ena && mem_wr_ena && is_io;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = 16'(cnt_q + 16'd1);
        if (cnt_q == LAST_CNT) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // During init the BRAM port carries the copy; in RUN it follows the core.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = mem_addr[BRAM_AW-1:0];
    bram_wdata = mem_wdata;
    if (!run) begin
      if (pend_q) begin
        bram_en    = 1'b1;
        bram_we    = 1'b1;
        bram_addr  = cnt_prev_q;
        bram_wdata = rom_data;
      end
    end else if (mem_mem_ena && !is_io) begin
      bram_en = 1'b1;
      bram_we = mem_wr_ena;
    end
  end

  always_comb begin
    mem_rdata = rdata_hold_q;
    if (rd_pend_q) mem_rdata = io_sel_q ? sw_sync : bram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      cnt_prev_q   <= '0;
      pend_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
      init_done_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      io_sel_q     <= 1'b0;
      rdata_hold_q <= '0;
      hex_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cnt_prev_q   <= cnt_q[BRAM_AW-1:0];
      pend_q       <= (state_q == S_INIT);
      cpu_hold_q   <= (state_d != S_RUN);
      init_done_q  <= (state_d == S_RUN);
      rd_pend_q    <= core_rd;
      io_sel_q     <= is_io;
      rdata_hold_q <= mem_rdata;
      if (core_io_wr) hex_q <= mem_wdata;
    end
  end

  assign rom_addr  = cnt_q[BRAM_AW-1:0];
  assign cpu_hold  = cpu_hold_q;
  assign init_done = init_done_q;
  assign hex_o     = hex_q;

endmodule

// File: tb/tb_slc3_mem_subsystem.sv
// Bench for slc3_mem_subsystem: ROM/BRAM models, init-copy checks, a vector table
// for RUN accesses, and randomized accesses checked against a memory-map model.
module tb_slc3_mem_subsystem;

  localparam int unsigned NW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_mem_ena, mem_wr_ena;
  logic [15:0] sw_i, hex_o;
  logic        cpu_hold, init_done;
  logic [15:0] rom_addr, rom_data;
  logic        bram_en, bram_we;
  logic [15:0] bram_addr, bram_wdata, bram_rdata;

  always #5 clk = ~clk;

  slc3_mem_subsystem #(
    .INIT_WORDS (NW),
    .IO_ADDR    (16'hFFFF),
    .BRAM_AW    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_mem_ena (mem_mem_ena),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rdata   (mem_rdata),
    .sw_i        (sw_i),
    .hex_o       (hex_o),
    .cpu_hold    (cpu_hold),
    .init_done   (init_done),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_wdata  (bram_wdata),
    .bram_rdata  (bram_rdata)
  );

  // ROM image: word i = 3000 + i, 1-cycle latency.
  always @(posedge clk) rom_data <= 16'h3000 + rom_addr;

  // Write-first BRAM.
  logic [15:0] bram_mem [0:65535];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        bram_mem[bram_addr] <= bram_wdata;
        bram_rdata          <= bram_wdata;
      end else begin
        bram_rdata <= bram_mem[bram_addr];
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int unsigned cyc;
  } wr_t;
  wr_t         wlog[$];
  int unsigned cyc_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bram_en && bram_we) wlog.push_back('{bram_addr, bram_wdata, cyc_cnt});
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then run the copy while the core hammers the I/O address with writes.
  task automatic run_init();
    int base;
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b1;
    mem_addr    = 16'hFFFF;
    mem_wdata   = 16'h5555;
    reset       = 1'b1;
    tick();
    chk16("rst_hex", hex_o, 16'h0);
    chk1("rst_cpu_hold", cpu_hold, 1'b1);
    chk16("rst_rom_addr", rom_addr, 16'h0);
    chk1("rst_init_done", init_done, 1'b0);
    chk16("rst_rdata", mem_rdata, 16'h0);
    chk1("rst_bram_en", bram_en, 1'b0);
    base  = wlog.size();
    reset = 1'b0;
    for (int k = 1; k <= int'(NW) + 1; k++) begin
      tick();
      chk1($sformatf("cpu_hold_c%0d", k), cpu_hold, k <= int'(NW));
      chk1($sformatf("init_done_c%0d", k), init_done, k > int'(NW));
    end
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    chk16("init_hex", hex_o, 16'h0);
    chk16("init_rdata", mem_rdata, 16'h0);
    chk16("copy_count", 16'(wlog.size() - base), 16'(NW));
    for (int i = 0; i < int'(NW); i++) begin
      if (base + i < wlog.size()) begin
        chk16($sformatf("copy_addr%0d", i), wlog[base+i].a, 16'(i));
        chk16($sformatf("copy_data%0d", i), wlog[base+i].d, 16'h3000 + 16'(i));
        if (i > 0)
          chk1($sformatf("copy_consec%0d", i),
               wlog[base+i].cyc == wlog[base+i-1].cyc + 1, 1'b1);
      end
    end
  endtask

  typedef struct {
    logic        ena;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        x_en;
    logic        x_we;
    logic        chk_rd;
    logic [15:0] x_rd;
    logic [15:0] x_hex;
  } vec_t;
  vec_t vec[10];

  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] hex_m, exp_rd, swv;
  logic        exp_known;

  initial begin
    reset       = 1'b1;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sw_i        = '0;

    vec[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vec[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
    vec[2] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
    vec[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h7777, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
    vec[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A5, 16'h0000};
    vec[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h00A5, 16'h1234};
    vec[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3000, 16'h1234};
    vec[7] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A5, 16'h1234};
    vec[8] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3001, 16'h1234};
    vec[9] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3003, 16'h1234};

    tick();
    run_init();

    for (int i = 0; i < int'(NW); i++) ref_mem[16'(i)] = 16'h3000 + 16'(i);
    hex_m = 16'h0;

    sw_i = 16'h00A5;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      mem_mem_ena = vec[i].ena;
      mem_wr_ena  = vec[i].wr;
      mem_addr    = vec[i].addr;
      mem_wdata   = vec[i].wdata;
      #1;
      chk1($sformatf("v%0d_bram_en", i), bram_en, vec[i].x_en);
      chk1($sformatf("v%0d_bram_we", i), bram_we, vec[i].x_we);
      if (vec[i].x_en) chk16($sformatf("v%0d_bram_addr", i), bram_addr, vec[i].addr);
      if (vec[i].ena && vec[i].wr && vec[i].addr != 16'hFFFF) ref_mem[vec[i].addr] = vec[i].wdata;
      tick();
      if (vec[i].chk_rd) chk16($sformatf("v%0d_rdata", i), mem_rdata, vec[i].x_rd);
      chk16($sformatf("v%0d_hex", i), hex_o, vec[i].x_hex);
    end
    hex_m = 16'h1234;

    // Switch change: not yet visible one cycle later, visible two cycles later.
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b0;
    mem_addr    = 16'hFFFF;
    sw_i        = 16'h5A5A;
    tick();
    chk16("sw_old", mem_rdata, 16'h00A5);
    tick();
    tick();
    chk16("sw_new", mem_rdata, 16'h5A5A);
    mem_mem_ena = 1'b0;
    exp_rd      = 16'h5A5A;
    exp_known   = 1'b1;

    swv  = 16'($urandom);
    sw_i = swv;
    repeat (3) tick();
    for (int n = 0; n < 400; n++) begin
      int unsigned sel;
      sel         = $urandom_range(0, 9);
      mem_mem_ena = ($urandom_range(0, 3) != 0);
      mem_wr_ena  = 1'($urandom_range(0, 1));
      mem_addr    = (sel == 9) ? 16'hFFFF : (sel == 8) ? 16'h0010 : 16'(sel);
      mem_wdata   = 16'($urandom);
      #1;
      chk1("rnd_bram_en", bram_en, mem_mem_ena && mem_addr != 16'hFFFF);
      chk1("rnd_bram_we", bram_we, mem_mem_ena && mem_wr_ena && mem_addr != 16'hFFFF);
      if (mem_mem_ena && !mem_wr_ena) begin
        if (mem_addr == 16'hFFFF) begin
          exp_rd    = swv;
          exp_known = 1'b1;
        end else if (ref_mem.exists(mem_addr)) begin
          exp_rd    = ref_mem[mem_addr];
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
      end else if (mem_mem_ena && mem_wr_ena) begin
        if (mem_addr == 16'hFFFF) hex_m = mem_wdata;
        else ref_mem[mem_addr] = mem_wdata;
      end
      tick();
      if (exp_known) chk16("rnd_rdata", mem_rdata, exp_rd);
      chk16("rnd_hex", hex_o, hex_m);
    end

    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b1;
    mem_addr    = 16'hFFFF;
    mem_wdata   = 16'h1234;
    tick();
    chk16("pre_rst_hex", hex_o, 16'h1234);
    mem_mem_ena = 1'b0;
    tick();

    run_init();

    // Back-to-back reads after re-copy: 0000, FFFF, 0001, 0002, 0003.
    sw_i = 16'h00A5;
    repeat (3) tick();
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b0;
    mem_addr    = 16'h0000;
    tick();
    mem_addr = 16'hFFFF;
    chk16("b2b_rd0", mem_rdata, 16'h3000);
    tick();
    mem_addr = 16'h0001;
    chk16("b2b_rdio", mem_rdata, 16'h00A5);
    for (int i = 1; i < int'(NW); i++) begin
      tick();
      mem_addr = 16'(i + 1);
      chk16($sformatf("b2b_rd%0d", i), mem_rdata, 16'h3000 + 16'(i));
    end
    mem_mem_ena = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
